// File: rtl/store_array.sv
// store_array: ROWS x COLS bit array written one column per beat, with a
// serial readout (scan) FSM that streams the whole array out LSB-first.
// Optional build macro STORE_ARRAY_PARITY_EN adds a per-write parity input
// (wr_par) and a per-column parity error flag vector (col_perr).
module store_array #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  localparam int unsigned CW = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [CW-1:0]        wr_col,
  input  logic [ROWS-1:0]      wr_data,
`ifdef STORE_ARRAY_PARITY_EN
  input  logic                 wr_par,
  output logic [COLS-1:0]      col_perr,
`endif
  output logic [ROWS*COLS-1:0] out,
  output logic [COLS-1:0]      col_vld,
  input  logic                 scan_start,
  output logic                 scan_busy,
  output logic                 scan_valid,
  input  logic                 scan_ready,
  output logic                 scan_bit,
  output logic                 scan_last
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N-1:0]        array_q, array_d;
  logic [COLS-1:0]     col_vld_q, col_vld_d;
`ifdef STORE_ARRAY_PARITY_EN
  logic [COLS-1:0]     col_perr_q, col_perr_d;
`endif

  logic wr_fire;
  logic col_ok;

  // Writes are blocked while scanning so the streamed image stays coherent.
  assign wr_ready = (state_q == StIdle) && !rst && !clr;
  assign wr_fire  = wr_valid && wr_ready;
  // Compare in 32 bits so non-power-of-two COLS can flag out-of-range columns.
  assign col_ok   = 32'(wr_col) < COLS;

  // Next-state: clear has priority, then column write and scan sequencing.
  always_comb begin
    array_d   = array_q;
    col_vld_d = col_vld_q;
    state_d   = state_q;
    idx_d     = idx_q;
`ifdef STORE_ARRAY_PARITY_EN
    col_perr_d = col_perr_q;
`endif
    if (clr) begin
      array_d   = '0;
      col_vld_d = '0;
      state_d   = StIdle;
      idx_d     = '0;
`ifdef STORE_ARRAY_PARITY_EN
      col_perr_d = '0;
`endif
    end else begin
      if (wr_fire && col_ok) begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          array_d[r * COLS + 32'(wr_col)] = wr_data[r];
        end
        col_vld_d[wr_col] = 1'b1;
`ifdef STORE_ARRAY_PARITY_EN
        col_perr_d[wr_col] = (wr_par != ^wr_data);
`endif
      end
      unique case (state_q)
        StIdle: begin
          if (scan_start) begin
            state_d = StShift;
            idx_d   = '0;
          end
        end
        StShift: begin
          if (scan_ready) begin
            if (idx_q == LastIdx) begin
              state_d = StIdle;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      array_q   <= '0;
      col_vld_q <= '0;
      state_q   <= StIdle;
      idx_q     <= '0;
`ifdef STORE_ARRAY_PARITY_EN
      col_perr_q <= '0;
`endif
    end else begin
      array_q   <= array_d;
      col_vld_q <= col_vld_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
`ifdef STORE_ARRAY_PARITY_EN
      col_perr_q <= col_perr_d;
`endif
    end
  end

  // Scan outputs are forced low outside SHIFT.
  always_comb begin
    scan_busy  = (state_q == StShift);
    scan_valid = scan_busy;
    scan_bit   = scan_busy && array_q[idx_q];
    scan_last  = scan_busy && (idx_q == LastIdx);
  end

  assign out     = array_q;
  assign col_vld = col_vld_q;
`ifdef STORE_ARRAY_PARITY_EN
  assign col_perr = col_perr_q;
`endif

endmodule
